uart_rx_core: RTL

UART_RX_CORE -- requirements
Module: uart_rx_core

---
 rtl/uart_rx_core.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/uart_rx_core.sv
// UART receiver core: synchronizes rxd, finds the start bit, samples 8N1 frames mid-bit
// and holds the received byte with ready/framing/overrun status for a register front end.
module uart_rx_core #(
  parameter int unsigned DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rxd,
  input  logic [DIV_W-1:0] divr,
  input  logic             rd_clr,
  output logic [7:0]       dout,
  output logic             rx_ready,
  output logic             err_frame,
  output logic             err_overrun
);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  state_e           state_q, state_d;
  logic [2:0]       sync_q;
  logic [2:0]       valid_q;
  logic             rxd_p_q;
  logic             armed_q;
  logic             rxd_s;
  logic             sample;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [2:0]       bidx_q, bidx_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       dout_q, dout_d;
  logic             ready_q, ready_d;
  logic             ferr_q, ferr_d;
  logic             ovr_q, ovr_d;

  // Synchronizer output is registered once more so the start bit lands at mid-bit plus three.
  assign rxd_s  = sync_q[2];
  assign sample = (cnt_q == '0);

  // armed_q only rises after the line is genuinely seen high, so a line held low through
  // reset never produces a false falling edge against the preset synchronizer value.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q  <= 3'b111;
      valid_q <= 3'b000;
      rxd_p_q <= 1'b1;
      armed_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[1:0], rxd};
      valid_q <= {valid_q[1:0], 1'b1};
      rxd_p_q <= rxd_s;
      armed_q <= armed_q | (valid_q[2] & rxd_s);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      div_q   <= '0;
      bidx_q  <= 3'd0;
      shift_q <= 8'h00;
      dout_q  <= 8'h00;
      ready_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      bidx_q  <= bidx_d;
      shift_q <= shift_d;
      dout_q  <= dout_d;
      ready_q <= ready_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    bidx_d  = bidx_q;
    shift_d = shift_q;
    dout_d  = dout_q;
    ready_d = ready_q;
    ferr_d  = ferr_q;
    ovr_d   = ovr_q;

    if (rd_clr) begin
      ready_d = 1'b0;
      ferr_d  = 1'b0;
      ovr_d   = 1'b0;
    end

    unique case (state_q)
      StIdle: begin
        if (armed_q && !rxd_s && rxd_p_q && (divr >= DIV_W'(4))) begin
          div_d   = divr;
          cnt_d   = (divr >> 1) - DIV_W'(1);
          state_d = StStart;
        end
      end
      StStart: begin
        if (!sample) begin
          cnt_d = cnt_q - DIV_W'(1);
        end else if (!rxd_s) begin
          cnt_d   = div_q - DIV_W'(1);
          bidx_d  = 3'd0;
          state_d = StData;
        end else begin
          state_d = StIdle;
        end
      end
      StData: begin
        if (!sample) begin
          cnt_d = cnt_q - DIV_W'(1);
        end else begin
          shift_d = {rxd_s, shift_q[7:1]};
          cnt_d   = div_q - DIV_W'(1);
          if (bidx_q == 3'd7) begin
            state_d = StStop;
          end else begin
            bidx_d = bidx_q + 3'd1;
          end
        end
      end
      StStop: begin
        if (!sample) begin
          cnt_d = cnt_q - DIV_W'(1);
        end else begin
          // A read landing on the same cycle consumes the old byte, so no overrun.
          dout_d  = shift_q;
          ready_d = 1'b1;
          ferr_d  = ~rxd_s;
          ovr_d   = rd_clr ? 1'b0 : (ovr_q | ready_q);
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign dout        = dout_q;
  assign rx_ready    = ready_q;
  assign err_frame   = ferr_q;
  assign err_overrun = ovr_q;

endmodule
